// File: rtl/digimax_mixer.sv
// DigiMax four-channel mixer: snapshots the four 8-bit DAC latches on a
// sample strobe, sums them into a stereo pair over a short sequencer run,
// applies the master volume and presents signed 16-bit stereo samples.
module digimax_mixer (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sample_stb,
  input  logic [7:0]         dac_0,
  input  logic [7:0]         dac_1,
  input  logic [7:0]         dac_2,
  input  logic [7:0]         dac_3,
  input  logic [3:0]         vol,
  input  logic               clr_ovr,
  output logic signed [15:0] audio_l,
  output logic signed [15:0] audio_r,
  output logic               out_valid,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    L0    = 3'd1,
    L1    = 3'd2,
    R0    = 3'd3,
    R1    = 3'd4,
    SCALE = 3'd5
  } state_t;

  state_t state, next_state;

  logic [7:0]         snap_0, snap_1, snap_2, snap_3;
  logic [3:0]         vol_snap;
  logic signed [8:0]  acc;
  logic signed [8:0]  sum_l, sum_r;

  logic signed [8:0]  s0_ext, s1_ext, s2_ext, s3_ext;
  logic signed [12:0] sum_l_wide, sum_r_wide, vol_wide;
  logic signed [12:0] prod_l, prod_r;

  // Offset-binary bytes become signed samples by flipping the MSB; the extra
  // top bit is the sign extension needed for the 9-bit channel sums.
  assign s0_ext = {~snap_0[7], ~snap_0[7], snap_0[6:0]};
  assign s1_ext = {~snap_1[7], ~snap_1[7], snap_1[6:0]};
  assign s2_ext = {~snap_2[7], ~snap_2[7], snap_2[6:0]};
  assign s3_ext = {~snap_3[7], ~snap_3[7], snap_3[6:0]};

  // Sum times volume is at most 256*15 in magnitude, so 13 signed bits hold
  // it exactly and the final shift by 3 fills the 16-bit output.
  assign sum_l_wide = {{4{sum_l[8]}}, sum_l};
  assign sum_r_wide = {{4{sum_r[8]}}, sum_r};
  assign vol_wide   = {9'b0, vol_snap};
  assign prod_l     = sum_l_wide * vol_wide;
  assign prod_r     = sum_r_wide * vol_wide;

  assign busy = (state != IDLE);

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a fixed walk L0-L1-R0-R1-SCALE once a strobe is taken.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (sample_stb) next_state = L0;
      L0:      next_state = L1;
      L1:      next_state = R0;
      R0:      next_state = R1;
      R1:      next_state = SCALE;
      SCALE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: snapshot in IDLE, accumulate per channel, scale and publish.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_0    <= 8'h00;
      snap_1    <= 8'h00;
      snap_2    <= 8'h00;
      snap_3    <= 8'h00;
      vol_snap  <= 4'h0;
      acc       <= 9'sd0;
      sum_l     <= 9'sd0;
      sum_r     <= 9'sd0;
      audio_l   <= 16'sd0;
      audio_r   <= 16'sd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sample_stb) begin
            snap_0   <= dac_0;
            snap_1   <= dac_1;
            snap_2   <= dac_2;
            snap_3   <= dac_3;
            vol_snap <= vol;
          end
        end
        L0:    acc   <= s0_ext;
        L1:    sum_l <= acc + s2_ext;
        R0:    acc   <= s1_ext;
        R1:    sum_r <= acc + s3_ext;
        SCALE: begin
          audio_l   <= {prod_l, 3'b000};
          audio_r   <= {prod_r, 3'b000};
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sticky overrun: a strobe during a run sets it and wins over a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (sample_stb && busy) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_digimax_mixer.sv
// Directed self-checking bench for the DigiMax stereo mixer.
module tb_digimax_mixer;

  logic               clk;
  logic               reset_n;
  logic               sample_stb;
  logic [7:0]         dac_0, dac_1, dac_2, dac_3;
  logic [3:0]         vol;
  logic               clr_ovr;
  logic signed [15:0] audio_l, audio_r;
  logic               out_valid, busy, overrun;

  int nvec = 0;
  int nerr = 0;

  digimax_mixer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_stb (sample_stb),
    .dac_0      (dac_0),
    .dac_1      (dac_1),
    .dac_2      (dac_2),
    .dac_3      (dac_3),
    .vol        (vol),
    .clr_ovr    (clr_ovr),
    .audio_l    (audio_l),
    .audio_r    (audio_r),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dacs(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d,
                          input logic [3:0] v);
    dac_0 = a; dac_1 = b; dac_2 = c; dac_3 = d; vol = v;
  endtask

  // Pulse the strobe for one edge, then count edges until out_valid (bounded).
  task automatic strobe_and_wait(output int lat);
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    nvec++;
    if ({out_valid, busy, overrun} !== 3'b000) begin
      nerr++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {out_valid, busy, overrun});
    end
    nvec++;
    if (audio_l !== 16'h0000 || audio_r !== 16'h0000) begin
      nerr++;
      $display("[TB] FAIL reset_audio: got %h/%h expected 0000/0000", audio_l, audio_r);
    end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_midscale();
    set_dacs(8'h80, 8'h80, 8'h80, 8'h80, 4'd15);
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      nvec++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
        nerr++;
        $display("[TB] FAIL mid_busy_edge%0d: got busy=%b valid=%b expected busy=1 valid=0",
                 e, busy, out_valid);
      end
      if (e < 5) tick();
    end
    tick();
    nvec++;
    if (out_valid !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("[TB] FAIL mid_edge6: got valid=%b busy=%b expected valid=1 busy=0",
               out_valid, busy);
    end
    nvec++;
    if (audio_l !== 16'h0000 || audio_r !== 16'h0000) begin
      nerr++;
      $display("[TB] FAIL mid_audio: got %h/%h expected 0000/0000", audio_l, audio_r);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("[TB] FAIL mid_valid_one_cycle: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_fullscale();
    int lat;
    set_dacs(8'hFF, 8'h00, 8'hFF, 8'h00, 4'd15);
    strobe_and_wait(lat);
    nvec++;
    if (lat !== 6) begin
      nerr++;
      $display("[TB] FAIL full_latency: got %0d expected 6", lat);
    end
    nvec++;
    if (audio_l !== 16'h7710 || audio_r !== 16'h8800) begin
      nerr++;
      $display("[TB] FAIL full_audio: got %h/%h expected 7710/8800", audio_l, audio_r);
    end
    set_dacs(8'h80, 8'h80, 8'h80, 8'h80, 4'd0);
    tick(); tick(); tick();
    nvec++;
    if (audio_l !== 16'h7710 || audio_r !== 16'h8800) begin
      nerr++;
      $display("[TB] FAIL full_hold: got %h/%h expected 7710/8800", audio_l, audio_r);
    end
  endtask

  task automatic test_lsb_snapshot();
    int lat;
    set_dacs(8'h81, 8'h7F, 8'h80, 8'h80, 4'd1);
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    set_dacs(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'hF);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    nvec++;
    if (lat !== 6) begin
      nerr++;
      $display("[TB] FAIL lsb_latency: got %0d expected 6", lat);
    end
    nvec++;
    if (audio_l !== 16'h0008 || audio_r !== 16'hFFF8) begin
      nerr++;
      $display("[TB] FAIL lsb_audio: got %h/%h expected 0008/fff8", audio_l, audio_r);
    end
  endtask

  task automatic test_vol_zero();
    int lat;
    set_dacs(8'hFF, 8'h00, 8'hFF, 8'h00, 4'd0);
    strobe_and_wait(lat);
    nvec++;
    if (out_valid !== 1'b1 || audio_l !== 16'h0000 || audio_r !== 16'h0000) begin
      nerr++;
      $display("[TB] FAIL vol0: got valid=%b %h/%h expected valid=1 0000/0000",
               out_valid, audio_l, audio_r);
    end
  endtask

  task automatic test_overrun();
    int pulses;
    set_dacs(8'hFF, 8'h00, 8'hFF, 8'h00, 4'd15);
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    tick(); tick();
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    nvec++;
    if (overrun !== 1'b1) begin
      nerr++;
      $display("[TB] FAIL ovr_set: got %b expected 1", overrun);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    nvec++;
    if (pulses !== 1) begin
      nerr++;
      $display("[TB] FAIL ovr_pulses: got %0d expected 1", pulses);
    end
    nvec++;
    if (overrun !== 1'b1) begin
      nerr++;
      $display("[TB] FAIL ovr_sticky: got %b expected 1", overrun);
    end
    sample_stb = 1'b1;
    tick();
    clr_ovr = 1'b1;
    tick();
    sample_stb = 1'b0;
    clr_ovr = 1'b0;
    nvec++;
    if (overrun !== 1'b1) begin
      nerr++;
      $display("[TB] FAIL ovr_set_wins: got %b expected 1", overrun);
    end
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    nvec++;
    if (overrun !== 1'b0) begin
      nerr++;
      $display("[TB] FAIL ovr_clear: got %b expected 0", overrun);
    end
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    set_dacs(8'hFF, 8'h00, 8'hFF, 8'h00, 4'd15);
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    nvec++;
    if (out_valid !== 1'b1 || audio_l !== 16'h7710 || audio_r !== 16'h8800) begin
      nerr++;
      $display("[TB] FAIL b2b_first: got valid=%b %h/%h expected valid=1 7710/8800",
               out_valid, audio_l, audio_r);
    end
    set_dacs(8'h90, 8'h70, 8'h88, 8'h78, 4'd2);
    strobe_and_wait(lat);
    nvec++;
    if (lat !== 6) begin
      nerr++;
      $display("[TB] FAIL b2b_latency: got %0d expected 6", lat);
    end
    nvec++;
    if (audio_l !== 16'h0180 || audio_r !== 16'hFE80) begin
      nerr++;
      $display("[TB] FAIL b2b_second: got %h/%h expected 0180/fe80", audio_l, audio_r);
    end
    nvec++;
    if (overrun !== 1'b0) begin
      nerr++;
      $display("[TB] FAIL b2b_overrun: got %b expected 0", overrun);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    set_dacs(8'hFF, 8'h00, 8'hFF, 8'h00, 4'd15);
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    nvec++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || audio_l !== 16'h0000 || audio_r !== 16'h0000) begin
      nerr++;
      $display("[TB] FAIL abort_async: got busy=%b valid=%b %h/%h expected 0 0 0000/0000",
               busy, out_valid, audio_l, audio_r);
    end
    tick();
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    nvec++;
    if (pulses !== 0 || busy !== 1'b0) begin
      nerr++;
      $display("[TB] FAIL abort_no_valid: got pulses=%0d busy=%b expected 0 0", pulses, busy);
    end
  endtask

  // Run every scenario in turn and report.
  initial begin
    reset_n    = 1'b1;
    sample_stb = 1'b0;
    clr_ovr    = 1'b0;
    set_dacs(8'h80, 8'h80, 8'h80, 8'h80, 4'd0);
    test_reset();
    test_midscale();
    test_fullscale();
    test_lsb_snapshot();
    test_vol_zero();
    test_overrun();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
